// File: rtl/RS5_pkg.sv
// Shared types for the iterative divider: FSM states, operation encoding, limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package RS5_pkg;

  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_INIT = 2'b01,
    D_CALC = 2'b10,
    D_SIGN = 2'b11
  } div_states_e;

  typedef enum logic [1:0] {
    DIV_S = 2'b00,
    DIVU  = 2'b01,
    REM_S = 2'b10,
    REMU  = 2'b11
  } div_op_e;

  // Widest step chain the unit is built for.
  localparam int DIV_BPC_MAX = 4;

endpackage

// File: rtl/rs5_div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module rs5_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_o
);

  logic [XLEN+1:0] shifted_d;
  logic [XLEN+1:0] diff_d;

  // Top bit of the difference is the borrow: set means the divisor did not fit.
  always_comb begin
    shifted_d = {rem_i, bit_i};
    diff_d    = shifted_d - {2'b00, div_i};
    q_o       = ~diff_d[XLEN+1];
    rem_o     = q_o ? diff_d[XLEN:0] : shifted_d[XLEN:0];
  end

endmodule

// File: rtl/rs5_iter_divider.sv
// Multi-cycle DIV/DIVU/REM/REMU unit retiring BITS_PER_CYCLE quotient bits per cycle.
// Latency: 3+XLEN/BITS_PER_CYCLE cycles full divide; 2 cycles for special, early-out or reuse.
// Backpressure: busy_o high while occupied; start_i ignored then. flush_i aborts silently.
module rs5_iter_divider
  import RS5_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_OUT      = 1,
  parameter int REUSE          = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int BPC  = (BITS_PER_CYCLE > DIV_BPC_MAX) ? DIV_BPC_MAX : BITS_PER_CYCLE;
  localparam int N    = XLEN / BPC;
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  div_states_e     state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] qa_q;       // dividend bits shift out the top, quotient bits shift in below
  logic [XLEN:0]   rem_q;      // partial remainder with headroom bit for the trial subtract
  logic [XLEN-1:0] bmag_q;
  logic            qneg_q, rneg_q;
  logic [CNTW-1:0] cnt_q;      // remaining CALC iterations after the current one
  logic            busy_q, valid_q;
  logic [XLEN-1:0] result_q;
  logic            tag_vld_q, tag_s_q;
  logic [XLEN-1:0] tag_a_q, tag_b_q, tag_quo_q, tag_rem_q;

  logic            is_signed_d, a_neg_d, b_neg_d;
  logic [XLEN-1:0] a_mag_d, b_mag_d;
  logic            b_zero_d, ovf_d, small_d, hit_d, special_d;
  logic [XLEN-1:0] early_q_d, early_r_d;
  logic [XLEN-1:0] quo_fin_d, rem_fin_d, sel_fin_d, qa_shift_d;
  logic [BPC-1:0]  qbits_d;
  logic [XLEN:0]   rem_last_d;

  // Operand magnitudes, signs and the short-circuit cases evaluated in D_INIT.
  always_comb begin
    is_signed_d = ~op_q[0];
    a_neg_d     = is_signed_d & a_q[XLEN-1];
    b_neg_d     = is_signed_d & b_q[XLEN-1];
    a_mag_d     = a_neg_d ? -a_q : a_q;
    b_mag_d     = b_neg_d ? -b_q : b_q;
    b_zero_d    = (b_q == '0);
    ovf_d       = is_signed_d && (a_q == XMIN) && (b_q == '1);
    small_d     = (EARLY_OUT != 0) && (a_mag_d < b_mag_d);
    hit_d       = (REUSE != 0) && tag_vld_q && (tag_a_q == a_q) && (tag_b_q == b_q)
                  && (tag_s_q == is_signed_d);
    special_d   = b_zero_d | ovf_d | small_d | hit_d;
    if (b_zero_d) begin
      early_q_d = '1;
      early_r_d = a_q;
    end else if (ovf_d) begin
      early_q_d = XMIN;
      early_r_d = '0;
    end else if (small_d) begin
      early_q_d = '0;
      early_r_d = a_q;
    end else begin
      early_q_d = tag_quo_q;
      early_r_d = tag_rem_q;
    end
  end

  // Chain of restoring steps; step 0 consumes the most significant pending dividend bit.
  for (genvar k = 0; k < BPC; k++) begin : g_step
    logic [XLEN:0] rem_in;
    logic [XLEN:0] rem_out;
    logic          q;
    if (k == 0) begin : g_first
      assign rem_in = rem_q;
    end else begin : g_next
      assign rem_in = g_step[k-1].rem_out;
    end
    rs5_div_step #(.XLEN(XLEN)) u_step (
      .rem_i (rem_in),
      .bit_i (qa_q[XLEN-1-k]),
      .div_i (bmag_q),
      .rem_o (rem_out),
      .q_o   (q)
    );
    assign qbits_d[BPC-1-k] = q;
  end

  assign rem_last_d = g_step[BPC-1].rem_out;

  // Shifted quotient register and sign-corrected final results.
  always_comb begin
    qa_shift_d = (qa_q << BPC) | XLEN'(qbits_d);
    quo_fin_d  = qneg_q ? -qa_q : qa_q;
    rem_fin_d  = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    sel_fin_d  = op_q[1] ? rem_fin_d : quo_fin_d;
  end

  // Control FSM, datapath registers, registered outputs and the reuse tag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= D_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      qa_q      <= '0;
      rem_q     <= '0;
      bmag_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      tag_vld_q <= 1'b0;
      tag_s_q   <= 1'b0;
      tag_a_q   <= '0;
      tag_b_q   <= '0;
      tag_quo_q <= '0;
      tag_rem_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (flush_i) begin
        state_q   <= D_IDLE;
        busy_q    <= 1'b0;
        tag_vld_q <= 1'b0;
      end else begin
        case (state_q)
          D_IDLE: begin
            if (start_i) begin
              op_q    <= op_i;
              a_q     <= a_i;
              b_q     <= b_i;
              busy_q  <= 1'b1;
              state_q <= D_INIT;
            end
          end
          D_INIT: begin
            qneg_q <= a_neg_d ^ b_neg_d;
            rneg_q <= a_neg_d;
            if (special_d) begin
              result_q <= op_q[1] ? early_r_d : early_q_d;
              valid_q  <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= D_IDLE;
              if (!hit_d) begin
                tag_vld_q <= 1'b0;
              end
            end else begin
              qa_q    <= a_mag_d;
              bmag_q  <= b_mag_d;
              rem_q   <= '0;
              cnt_q   <= CNTW'(N - 1);
              state_q <= D_CALC;
            end
          end
          D_CALC: begin
            qa_q  <= qa_shift_d;
            rem_q <= rem_last_d;
            if (cnt_q == '0) begin
              state_q <= D_SIGN;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          D_SIGN: begin
            result_q  <= sel_fin_d;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= D_IDLE;
            tag_vld_q <= 1'b1;
            tag_s_q   <= is_signed_d;
            tag_a_q   <= a_q;
            tag_b_q   <= b_q;
            tag_quo_q <= quo_fin_d;
            tag_rem_q <= rem_fin_d;
          end
          default: begin
            state_q <= D_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_rs5_iter_divider.sv
// Directed and randomised checks of rs5_iter_divider across four configurations.
// Latency: n/a.
// Backpressure: n/a.
module tb_rs5_iter_divider;
  import RS5_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic [3:0]  start;
  logic [1:0]  op;
  logic [31:0] a32, b32;
  logic [63:0] a64, b64;
  logic [3:0]  busy, valid;
  logic [31:0] r0, r1, r2;
  logic [63:0] r3;

  int n_cmp = 0;
  int n_err = 0;

  rs5_iter_divider #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1), .REUSE(1)) u_d0 (
    .clk(clk), .reset_n(reset_n), .start_i(start[0]), .op_i(op), .a_i(a32), .b_i(b32),
    .flush_i(flush), .busy_o(busy[0]), .valid_o(valid[0]), .result_o(r0));
  rs5_iter_divider #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_OUT(0), .REUSE(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .start_i(start[1]), .op_i(op), .a_i(a32), .b_i(b32),
    .flush_i(flush), .busy_o(busy[1]), .valid_o(valid[1]), .result_o(r1));
  rs5_iter_divider #(.XLEN(32), .BITS_PER_CYCLE(4), .EARLY_OUT(1), .REUSE(1)) u_d2 (
    .clk(clk), .reset_n(reset_n), .start_i(start[2]), .op_i(op), .a_i(a32), .b_i(b32),
    .flush_i(flush), .busy_o(busy[2]), .valid_o(valid[2]), .result_o(r2));
  rs5_iter_divider #(.XLEN(64), .BITS_PER_CYCLE(2), .EARLY_OUT(1), .REUSE(1)) u_d3 (
    .clk(clk), .reset_n(reset_n), .start_i(start[3]), .op_i(op), .a_i(a64), .b_i(b64),
    .flush_i(flush), .busy_o(busy[3]), .valid_o(valid[3]), .result_o(r3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] res_of(input int u);
    case (u)
      0:       return {32'h0, r0};
      1:       return {32'h0, r1};
      2:       return {32'h0, r2};
      default: return r3;
    endcase
  endfunction

  // RISC-V reference semantics using the simulator's own division operators.
  function automatic logic [63:0] model(input int xl, input logic [1:0] o,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a3, b3, q3, r3m;
    logic [63:0] q6, r6;
    a3 = a[31:0];
    b3 = b[31:0];
    if (xl == 32) begin
      if (b3 == 32'h0) begin
        q3 = '1; r3m = a3;
      end else if (!o[0] && a3 == 32'h8000_0000 && b3 == 32'hFFFF_FFFF) begin
        q3 = a3; r3m = 32'h0;
      end else if (!o[0]) begin
        q3 = $signed(a3) / $signed(b3); r3m = $signed(a3) % $signed(b3);
      end else begin
        q3 = a3 / b3; r3m = a3 % b3;
      end
      return o[1] ? {32'h0, r3m} : {32'h0, q3};
    end
    if (b == 64'h0) begin
      q6 = '1; r6 = a;
    end else if (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q6 = a; r6 = 64'h0;
    end else if (!o[0]) begin
      q6 = $signed(a) / $signed(b); r6 = $signed(a) % $signed(b);
    end else begin
      q6 = a / b; r6 = a % b;
    end
    return o[1] ? r6 : q6;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op on instance u and wait for its result; lat < 0 skips the latency check.
  task automatic run(input int u, input logic [1:0] o, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int lat,
                     input string tag);
    int k;
    @(negedge clk);
    op = o; a32 = a[31:0]; b32 = b[31:0]; a64 = a; b64 = b;
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    chk({tag, " busy@t+1"}, 64'(busy[u]), 64'd1);
    k = 1;
    while (!valid[u] && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " valid"}, 64'(valid[u]), 64'd1);
    chk({tag, " busy@valid"}, 64'(busy[u]), 64'd0);
    chk({tag, " result"}, res_of(u), exp);
    if (lat >= 0) chk({tag, " latency"}, 64'(k), 64'(lat));
  endtask

  initial begin
    int seen;
    logic [1:0]  ro;
    logic [63:0] ra, rb;
    reset_n = 1'b0; flush = 1'b0; start = '0; op = '0;
    a32 = '0; b32 = '0; a64 = '0; b64 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset valid", 64'(valid), 64'd0);
    chk("reset result0", res_of(0), 64'd0);
    chk("reset result3", res_of(3), 64'd0);
    reset_n = 1'b1;

    run(0, DIVU,  100, 7, 14, 35, "divu 100/7");
    run(0, REMU,  100, 7, 2,  2,  "remu 100/7 reuse");
    run(0, DIV_S, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 35, "div -7/2");
    run(0, REM_S, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 2,  "rem -7/2 reuse");
    run(0, DIV_S, 5, 0, 32'hFFFF_FFFF, 2, "div 5/0");
    run(0, REMU,  5, 0, 5, 2, "remu 5/0");
    run(0, DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div min/-1");
    run(0, REM_S, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2, "rem min/-1");
    run(0, DIVU, 3, 10, 0, 2,  "divu 3/10 early");
    run(1, DIVU, 3, 10, 0, 35, "divu 3/10 no-early");

    // Flush ten cycles into a full divide.
    @(negedge clk);
    op = DIVU; a32 = 1000; b32 = 3; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy@t+11", 64'(busy[0]), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid[0]) seen = 1;
    end
    chk("flush no valid", 64'(seen), 64'd0);

    // Flush and start together: the start is dropped.
    @(negedge clk);
    start[0] = 1'b1; flush = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; flush = 1'b0;
    chk("flush+start busy", 64'(busy[0]), 64'd0);

    // Flush during the valid cycle leaves that pulse intact.
    @(negedge clk);
    op = DIVU; a32 = 5; b32 = 0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    chk("flush in valid cycle", 64'(valid[0]), 64'd1);
    chk("flush in valid result", res_of(0), 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    flush = 1'b0;

    run(0, DIVU, 1000, 3, 333, 35, "divu 1000/3 after flush");
    run(0, REMU, 1000, 3, 1,   2,  "remu 1000/3 reuse");

    // Reset in the middle of CALC.
    @(negedge clk);
    op = DIVU; a32 = 1000; b32 = 7; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset busy", 64'(busy[0]), 64'd0);
    chk("midreset valid", 64'(valid[0]), 64'd0);
    chk("midreset result", res_of(0), 64'd0);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid[0]) seen = 1;
    end
    chk("midreset no valid", 64'(seen), 64'd0);
    run(0, REMU, 1000, 3, 1, 35, "remu 1000/3 tag cleared");

    run(2, DIVU,  100, 7, 14, 11, "bpc4 divu 100/7");
    run(2, DIV_S, 32'hFFFF_FF9C, 7, 32'hFFFF_FFF2, 11, "bpc4 div -100/7");
    run(2, REM_S, 32'hFFFF_FF9C, 7, 32'hFFFF_FFFE, 2,  "bpc4 rem -100/7");
    run(3, DIVU, 64'd1000000000000, 7, 64'd142857142857, 35, "x64 divu");
    run(3, REMU, 64'd1000000000000, 7, 64'd1, 2, "x64 remu reuse");
    run(3, DIV_S, 64'hFFFF_FFFF_FFFF_FFF9, 2, 64'hFFFF_FFFF_FFFF_FFFD, 35, "x64 div -7/2");

    for (int u = 0; u < 4; u++) begin
      for (int i = 0; i < 12; i++) begin
        ro = 2'($urandom_range(0, 3));
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom} >> $urandom_range(0, 60);
        run(u, ro, ra, rb, model((u == 3) ? 64 : 32, ro, ra, rb), -1, "random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
